// File: rtl/tetris_input_pkg.sv
// ============================================================================
// Module      : tetris_input_pkg
// Description : Shared types and default timing constants for the move input path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tetris_input_pkg;

   typedef enum logic [1:0] {
      DIR_NONE  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DAS    = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   localparam int DAS_TICKS_DEF = 4;
   localparam int ARR_TICKS_DEF = 2;
   localparam int CNT_W_DEF     = 8;

   function automatic dir_e opposite_dir(input dir_e d);
      dir_e r;
      case (d)
         DIR_LEFT:  r = DIR_RIGHT;
         DIR_RIGHT: r = DIR_LEFT;
         default:   r = DIR_NONE;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/repeat_timer.sv
// ============================================================================
// Module      : repeat_timer
// Description : Tick-driven counter that flags the tick on which it reaches limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module repeat_timer
   import tetris_input_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             tick,
   input  logic [CNT_W-1:0] limit,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Expiry restarts the count, so cnt never runs past limit and never wraps.
   assign expire = tick & (cnt_q == limit);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (expire) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/move_autorepeat.sv
// ============================================================================
// Module      : move_autorepeat
// Description : Turns left/right button levels into move pulses with DAS/ARR repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_autorepeat
   import tetris_input_pkg::*;
#(
   parameter int DAS_TICKS = DAS_TICKS_DEF,
   parameter int ARR_TICKS = ARR_TICKS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn_l,
   input  logic btn_r,
   output logic move_l,
   output logic move_r,
   output logic repeating
);

   localparam logic [CNT_W-1:0] DAS_LIMIT = CNT_W'(DAS_TICKS - 1);
   localparam logic [CNT_W-1:0] ARR_LIMIT = CNT_W'(ARR_TICKS - 1);

   rep_state_e       state_q;
   rep_state_e       state_d;
   dir_e             dir_q;
   dir_e             dir_d;
   dir_e             pulse_dir;
   logic             prev_l_q;
   logic             prev_r_q;
   logic             move_l_q;
   logic             move_l_d;
   logic             move_r_q;
   logic             move_r_d;
   logic             repeating_q;
   logic             repeating_d;

   logic             press_l;
   logic             press_r;
   logic             release_l;
   logic             release_r;
   logic             act_left;
   logic             opp_press;
   logic             act_release;
   logic             other_held;

   logic             tmr_clear;
   logic             tmr_expire;
   logic [CNT_W-1:0] tmr_limit;

   assign press_l   = btn_l & ~prev_l_q;
   assign press_r   = btn_r & ~prev_r_q;
   assign release_l = ~btn_l & prev_l_q;
   assign release_r = ~btn_r & prev_r_q;

   // Events seen relative to the side currently driving the repeat.
   assign act_left    = (dir_q == DIR_LEFT);
   assign opp_press   = act_left ? press_r   : press_l;
   assign act_release = act_left ? release_l : release_r;
   assign other_held  = act_left ? btn_r     : btn_l;

   assign tmr_limit = (state_q == ST_REPEAT) ? ARR_LIMIT : DAS_LIMIT;

   repeat_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmr_clear),
      .tick   (tick),
      .limit  (tmr_limit),
      .expire (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      pulse_dir = DIR_NONE;
      tmr_clear = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tmr_clear = 1'b1;
            if (press_l) begin
               dir_d     = DIR_LEFT;
               pulse_dir = DIR_LEFT;
               state_d   = ST_DAS;
            end else if (press_r) begin
               dir_d     = DIR_RIGHT;
               pulse_dir = DIR_RIGHT;
               state_d   = ST_DAS;
            end
         end

         ST_DAS, ST_REPEAT: begin
            // A new opposite press and a hand-over on release both restart DAS on the other side.
            if (opp_press || (act_release && other_held)) begin
               dir_d     = opposite_dir(dir_q);
               pulse_dir = opposite_dir(dir_q);
               tmr_clear = 1'b1;
               state_d   = ST_DAS;
            end else if (act_release) begin
               dir_d     = DIR_NONE;
               tmr_clear = 1'b1;
               state_d   = ST_IDLE;
            end else if (tmr_expire) begin
               pulse_dir = dir_q;
               state_d   = ST_REPEAT;
            end
         end

         default: begin
            dir_d     = DIR_NONE;
            tmr_clear = 1'b1;
            state_d   = ST_IDLE;
         end
      endcase

      move_l_d    = (pulse_dir == DIR_LEFT);
      move_r_d    = (pulse_dir == DIR_RIGHT);
      repeating_d = (state_d == ST_REPEAT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         dir_q       <= DIR_NONE;
         prev_l_q    <= 1'b0;
         prev_r_q    <= 1'b0;
         move_l_q    <= 1'b0;
         move_r_q    <= 1'b0;
         repeating_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         prev_l_q    <= btn_l;
         prev_r_q    <= btn_r;
         move_l_q    <= move_l_d;
         move_r_q    <= move_r_d;
         repeating_q <= repeating_d;
      end
   end

   assign move_l    = move_l_q;
   assign move_r    = move_r_q;
   assign repeating = repeating_q;

endmodule

`default_nettype wire

// File: tb/tb_move_autorepeat.sv
// ============================================================================
// Module      : tb_move_autorepeat
// Description : Directed and randomized bench for move_autorepeat against a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_autorepeat;

   localparam int DAS = 4;
   localparam int ARR = 2;
   localparam int CW  = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tick  = 1'b0;
   logic btn_l = 1'b0;
   logic btn_r = 1'b0;
   logic move_l;
   logic move_r;
   logic repeating;

   move_autorepeat #(
      .DAS_TICKS (DAS),
      .ARR_TICKS (ARR),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .btn_l     (btn_l),
      .btn_r     (btn_r),
      .move_l    (move_l),
      .move_r    (move_r),
      .repeating (repeating)
   );

   always #5 clk = ~clk;

   int tests     = 0;
   int fails     = 0;
   int edge_n    = 0;
   int base      = 0;
   int tick_mode = 0;
   int rep_first = -1;
   int ql[$];
   int qr[$];

   always @(posedge clk) edge_n <= edge_n + 1;

   // Tick source: 0 = every cycle, 1 = every 3rd scenario edge, 2 = random.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (tick_mode)
            0:       tick = 1'b1;
            1:       tick = (((edge_n + 1 - base) % 3) == 0);
            default: tick = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Model: count ticks since the last anchoring move; moves fall at DAS, DAS+ARR, DAS+2*ARR...
   int m_side  = 0;
   int m_ticks = 0;
   bit m_prev_l = 1'b0;
   bit m_prev_r = 1'b0;
   bit exp_l    = 1'b0;
   bit exp_r    = 1'b0;
   bit exp_rep  = 1'b0;

   always @(posedge clk or negedge rst_n) begin : model
      bit pl, pr, rl, rr, opp, rel, other;
      if (!rst_n) begin
         m_side = 0; m_ticks = 0; m_prev_l = 0; m_prev_r = 0;
         exp_l = 0; exp_r = 0; exp_rep = 0;
      end else begin
         pl = btn_l && !m_prev_l;
         pr = btn_r && !m_prev_r;
         rl = !btn_l && m_prev_l;
         rr = !btn_r && m_prev_r;
         exp_l = 0;
         exp_r = 0;
         if (m_side == 0) begin
            if (pl) begin
               m_side = 1; m_ticks = 0; exp_l = 1;
            end else if (pr) begin
               m_side = 2; m_ticks = 0; exp_r = 1;
            end
         end else begin
            opp   = (m_side == 1) ? pr : pl;
            rel   = (m_side == 1) ? rl : rr;
            other = (m_side == 1) ? btn_r : btn_l;
            if (opp || (rel && other)) begin
               m_side = 3 - m_side; m_ticks = 0;
               exp_l = (m_side == 1); exp_r = (m_side == 2);
            end else if (rel) begin
               m_side = 0; m_ticks = 0;
            end else if (tick) begin
               m_ticks++;
               if (m_ticks >= DAS && ((m_ticks - DAS) % ARR) == 0) begin
                  exp_l = (m_side == 1); exp_r = (m_side == 2);
               end
            end
         end
         exp_rep  = (m_side != 0) && (m_ticks >= DAS);
         m_prev_l = btn_l;
         m_prev_r = btn_r;
      end
   end

   task automatic check_bit(string nm, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at edge %0d: got %b, expected %b", nm, edge_n, act, exp);
      end
   endtask

   task automatic check_int(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_q(string nm, int got[$], int exp[$]);
      string sg = "";
      string se = "";
      bit    ok;
      tests++;
      ok = (got.size() == exp.size());
      for (int i = 0; i < got.size(); i++) begin
         sg = {sg, $sformatf(" %0d", got[i])};
         if (ok && got[i] != exp[i]) ok = 0;
      end
      for (int i = 0; i < exp.size(); i++) se = {se, $sformatf(" %0d", exp[i])};
      if (!ok) begin
         fails++;
         $display("FAIL %s: pulse edges got {%s }, expected {%s }", nm, sg, se);
      end
   endtask

   // Per-cycle comparison against the model, plus pulse-edge recording for directed checks.
   always @(negedge clk) begin
      check_bit("move_l", move_l, exp_l);
      check_bit("move_r", move_r, exp_r);
      check_bit("repeating", repeating, exp_rep);
      tests++;
      if (move_l === 1'b1 && move_r === 1'b1) begin
         fails++;
         $display("FAIL exclusive at edge %0d: got both moves high, expected at most one", edge_n);
      end
      if (move_l === 1'b1) ql.push_back(edge_n - base);
      if (move_r === 1'b1) qr.push_back(edge_n - base);
      if (repeating === 1'b1 && rep_first < 0) rep_first = edge_n - base;
   end

   task automatic begin_scenario(int mode);
      btn_l = 1'b0;
      btn_r = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n     = 1'b1;
      tick_mode = mode;
      base      = edge_n;
      ql.delete();
      qr.delete();
      rep_first = -1;
   endtask

   // Returns just after edge k-1, so values driven now are first sampled at edge k.
   task automatic at_edge(int k);
      while (edge_n < base + k - 1) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin : stim
      int e[$];
      int nl[$];
      @(posedge clk);
      #2;

      // Tap
      begin_scenario(0);
      at_edge(10); btn_l = 1;
      at_edge(12); btn_l = 0;
      at_edge(16);
      e = '{10};   check_q("tap_l", ql, e);
      nl.delete(); check_q("tap_r", qr, nl);
      check_int("tap_rep_first", rep_first, -1);

      // Hold
      begin_scenario(0);
      at_edge(10); btn_l = 1;
      at_edge(21); btn_l = 0;
      at_edge(23);
      e = '{10, 14, 16, 18, 20}; check_q("hold_l", ql, e);
      check_q("hold_r", qr, nl);
      check_int("hold_rep_first", rep_first, 14);

      // Slow tick
      begin_scenario(1);
      at_edge(10); btn_r = 1;
      at_edge(30); btn_r = 0;
      at_edge(32);
      e = '{10, 21, 27}; check_q("slow_r", qr, e);
      check_q("slow_l", ql, nl);

      // Override and hand-back
      begin_scenario(0);
      at_edge(10); btn_l = 1;
      at_edge(15); btn_r = 1;
      at_edge(17); btn_r = 0;
      at_edge(23); btn_l = 0;
      at_edge(25);
      e = '{10, 14, 17, 21}; check_q("override_l", ql, e);
      e = '{15};             check_q("override_r", qr, e);

      // Simultaneous press
      begin_scenario(0);
      at_edge(10); btn_l = 1; btn_r = 1;
      at_edge(12); btn_l = 0;
      at_edge(14); btn_r = 0;
      at_edge(16);
      e = '{10}; check_q("simul_l", ql, e);
      e = '{12}; check_q("simul_r", qr, e);

      // Reset during a hold
      begin_scenario(0);
      at_edge(10); btn_l = 1;
      at_edge(16);
      check_bit("pre_rst_repeating", repeating, 1'b1);
      rst_n = 0;
      #1;
      check_bit("rst_move_l", move_l, 1'b0);
      check_bit("rst_repeating", repeating, 1'b0);
      at_edge(18); rst_n = 1;
      at_edge(25); btn_l = 0;
      at_edge(27);
      e = '{10, 14, 18, 22, 24}; check_q("reset_l", ql, e);

      // Random traffic with random ticks and occasional resets
      begin_scenario(2);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         if ($urandom_range(0, 11) == 0) btn_l = ~btn_l;
         if ($urandom_range(0, 11) == 0) btn_r = ~btn_r;
         if (rst_n == 1'b0) rst_n = 1'b1;
         else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
